// File: rtl/oh_cell2_tester.sv
// Stimulus/response engine for a 2-input stdcell: sweeps {a,b} = 00..11, waits a
// settle time, samples the synchronized cell output and scores it against TRUTH.
module oh_cell2_tester #(
    parameter logic [3:0] TRUTH  = 4'b0001,
    parameter int         SETTLE = 4,
    parameter int         LOOPS  = 1,
    parameter int         ECW    = 8
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           start,
    output logic           a,
    output logic           b,
    input  logic           z,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [ECW-1:0] err_count,
    output logic [3:0]     err_vec
);

    // Two synchronizer stages plus one sample cycle need at least two settle cycles.
    localparam int         SETTLE_EFF = (SETTLE < 2) ? 2 : SETTLE;
    localparam int         LOOPS_EFF  = (LOOPS < 1) ? 1 : LOOPS;
    localparam logic [7:0] CNT_LOAD   = 8'(SETTLE_EFF - 1);
    localparam logic [7:0] LAST_LOOP  = 8'(LOOPS_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t         r_state;
    logic [1:0]     r_idx;
    logic [7:0]     r_loop;
    logic [7:0]     r_count;
    logic           r_busy;
    logic           r_done;
    logic           r_pass;
    logic [ECW-1:0] r_errCount;
    logic [3:0]     r_errVec;
    logic           r_zMeta;
    logic           r_zSync;

    logic           w_mismatch;
    logic           w_errMax;
    logic           w_lastSample;

    // Case-inequality so that an X or Z from the cell is scored as a failure.
    assign w_mismatch   = (r_zSync !== TRUTH[r_idx]);
    assign w_errMax     = (r_errCount == {ECW{1'b1}});
    assign w_lastSample = (r_idx == 2'd3) && (r_loop == LAST_LOOP);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_zMeta <= 1'b0;
            r_zSync <= 1'b0;
        end else begin
            r_zMeta <= z;
            r_zSync <= r_zMeta;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_loop     <= 8'd0;
            r_count    <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_errCount <= '0;
            r_errVec   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_idx      <= 2'd0;
                        r_loop     <= 8'd0;
                        r_count    <= CNT_LOAD;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_errCount <= '0;
                        r_errVec   <= 4'd0;
                        r_state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_count == 8'd0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (w_mismatch) begin
                        if (!w_errMax) begin
                            r_errCount <= r_errCount + 1'b1;
                        end
                        r_errVec[r_idx] <= 1'b1;
                    end
                    // The final sample's own result must be folded into pass here.
                    if (w_lastSample) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= !w_mismatch && (r_errVec == 4'd0);
                        r_state <= ST_DONE;
                    end else begin
                        if (r_idx == 2'd3) begin
                            r_loop <= r_loop + 8'd1;
                        end
                        r_idx   <= r_idx + 2'd1;
                        r_count <= CNT_LOAD;
                        r_state <= ST_SETTLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign a         = r_idx[1];
    assign b         = r_idx[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_errCount;
    assign err_vec   = r_errVec;

endmodule

// File: tb/tb_oh_cell2_tester.sv
// Directed bench for oh_cell2_tester: four parameterizations, each driving a
// small behavioural cell model on z, with hand-computed results per scenario.
module tb_oh_cell2_tester;

    logic clk;
    logic nreset;
    int   errors;
    int   checks;
    int   cyc;

    // u0: defaults (NOR, SETTLE=4, LOOPS=1); z model chosen by mode0.
    logic       start0, a0, b0, z0, busy0, done0, pass0;
    logic [7:0] ec0;
    logic [3:0] ev0;
    int         mode0;
    // u1: LOOPS=3 with an AND cell on z.
    logic       start1, a1, b1, z1, busy1, done1, pass1;
    logic [7:0] ec1;
    logic [3:0] ev1;
    // u2: ECW=2, LOOPS=2; z is X (mode2=0) or an always-wrong OR (mode2=1).
    logic       start2, a2, b2, z2, busy2, done2, pass2;
    logic [1:0] ec2;
    logic [3:0] ev2;
    int         mode2;
    // u3: SETTLE=2 with an ideal NOR.
    logic       start3, a3, b3, z3, busy3, done3, pass3;
    logic [7:0] ec3;
    logic [3:0] ev3;

    assign z0 = (mode0 == 0) ? ~(a0 | b0) : 1'b0;
    assign z1 = a1 & b1;
    assign z2 = (mode2 == 1) ? (a2 | b2) : 1'bx;
    assign z3 = ~(a3 | b3);

    oh_cell2_tester u0 (
        .clk(clk), .nreset(nreset), .start(start0), .a(a0), .b(b0), .z(z0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0), .err_vec(ev0)
    );

    oh_cell2_tester #(.LOOPS(3)) u1 (
        .clk(clk), .nreset(nreset), .start(start1), .a(a1), .b(b1), .z(z1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1), .err_vec(ev1)
    );

    oh_cell2_tester #(.ECW(2), .LOOPS(2)) u2 (
        .clk(clk), .nreset(nreset), .start(start2), .a(a2), .b(b2), .z(z2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(ec2), .err_vec(ev2)
    );

    oh_cell2_tester #(.SETTLE(2)) u3 (
        .clk(clk), .nreset(nreset), .start(start3), .a(a3), .b(b3), .z(z3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(ec3), .err_vec(ev3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        nreset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({a0, b0, busy0, done0, pass0, ec0, ev0} !== 17'd0) begin
            errors++;
            $display("[TB] FAIL reset_u0: got %b expected all zero", {a0, b0, busy0, done0, pass0, ec0, ev0});
        end
        checks++;
        if ({a3, b3, busy3, done3, pass3, ec3, ev3} !== 17'd0) begin
            errors++;
            $display("[TB] FAIL reset_u3: got %b expected all zero", {a3, b3, busy3, done3, pass3, ec3, ev3});
        end
        nreset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nor_ideal();
        logic [1:0] expAb;
        mode0  = 0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            expAb = (c <= 20) ? 2'((c - 1) / 5) : 2'd3;
            checks++;
            if ({a0, b0} !== expAb) begin
                errors++;
                $display("[TB] FAIL nor_ab cyc%0d: got %b expected %b", c, {a0, b0}, expAb);
            end
            checks++;
            if (busy0 !== (c <= 20)) begin
                errors++;
                $display("[TB] FAIL nor_busy cyc%0d: got %b expected %b", c, busy0, (c <= 20));
            end
            checks++;
            if (done0 !== (c == 21)) begin
                errors++;
                $display("[TB] FAIL nor_done cyc%0d: got %b expected %b", c, done0, (c == 21));
            end
            if (c < 21) @(negedge clk);
        end
        checks++;
        if ({pass0, ec0, ev0} !== {1'b1, 8'd0, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL nor_result: got pass=%b ec=%0d ev=%b expected pass=1 ec=0 ev=0000", pass0, ec0, ev0);
        end
    endtask

    task automatic test_stuck0();
        mode0  = 1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 1;
        while (done0 !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 21) begin
            errors++;
            $display("[TB] FAIL stuck0_latency: got %0d expected 21", cyc);
        end
        checks++;
        if ({pass0, ec0, ev0} !== {1'b0, 8'd1, 4'b0001}) begin
            errors++;
            $display("[TB] FAIL stuck0_result: got pass=%b ec=%0d ev=%b expected pass=0 ec=1 ev=0001", pass0, ec0, ev0);
        end
        mode0 = 0;
    endtask

    task automatic test_and_loops();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 1;
        while (done1 !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 61) begin
            errors++;
            $display("[TB] FAIL and_latency: got %0d expected 61", cyc);
        end
        checks++;
        if ({pass1, ec1, ev1} !== {1'b0, 8'd6, 4'b1001}) begin
            errors++;
            $display("[TB] FAIL and_result: got pass=%b ec=%0d ev=%b expected pass=0 ec=6 ev=1001", pass1, ec1, ev1);
        end
    endtask

    task automatic test_saturation();
        mode2  = 0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (done2 !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 41) begin
            errors++;
            $display("[TB] FAIL x_latency: got %0d expected 41", cyc);
        end
        checks++;
        if (pass2 !== 1'b0 || ec2 == 2'd0) begin
            errors++;
            $display("[TB] FAIL x_result: got pass=%b ec=%0d expected pass=0 ec nonzero", pass2, ec2);
        end
        mode2  = 1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        checks++;
        if ({busy2, done2, pass2, ec2, ev2} !== {1'b1, 1'b0, 1'b0, 2'd0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL sat_clear: got busy=%b done=%b pass=%b ec=%0d ev=%b expected 1 0 0 0 0000", busy2, done2, pass2, ec2, ev2);
        end
        cyc = 1;
        while (done2 !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({pass2, ec2, ev2} !== {1'b0, 2'd3, 4'b1111}) begin
            errors++;
            $display("[TB] FAIL sat_result: got pass=%b ec=%0d ev=%b expected pass=0 ec=3 ev=1111", pass2, ec2, ev2);
        end
    endtask

    task automatic test_busy_start_and_reset();
        mode0  = 0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 1;
        while (cyc < 3) begin
            @(negedge clk);
            cyc++;
        end
        start0 = 1'b1;
        @(negedge clk);
        cyc++;
        start0 = 1'b0;
        while (cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if ({busy0, a0, b0} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL busy_start_ignored: got busy=%b ab=%b%b expected busy=1 ab=01", busy0, a0, b0);
        end
        while (cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        nreset = 1'b0;
        #1;
        checks++;
        if ({a0, b0, busy0, done0, pass0, ec0, ev0} !== 17'd0) begin
            errors++;
            $display("[TB] FAIL midrun_reset: got %b expected all zero", {a0, b0, busy0, done0, pass0, ec0, ev0});
        end
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 1;
        while (done0 !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 21) begin
            errors++;
            $display("[TB] FAIL post_reset_latency: got %0d expected 21", cyc);
        end
        checks++;
        if ({pass0, ec0, ev0} !== {1'b1, 8'd0, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL post_reset_result: got pass=%b ec=%0d ev=%b expected pass=1 ec=0 ev=0000", pass0, ec0, ev0);
        end
    endtask

    task automatic test_back_to_back();
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        cyc = 1;
        while (done3 !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 13 || pass3 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_first: got latency=%0d pass=%b expected 13 and 1", cyc, pass3);
        end
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        checks++;
        if ({busy3, done3, pass3, a3, b3, ec3, ev3} !== {1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL b2b_clear: got busy=%b done=%b pass=%b ab=%b%b expected 1 0 0 00", busy3, done3, pass3, a3, b3);
        end
        cyc = 1;
        while (done3 !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 13) begin
            errors++;
            $display("[TB] FAIL b2b_latency: got %0d expected 13", cyc);
        end
        checks++;
        if ({pass3, ec3, ev3} !== {1'b1, 8'd0, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL b2b_result: got pass=%b ec=%0d ev=%b expected pass=1 ec=0 ev=0000", pass3, ec3, ev3);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        mode0  = 0;
        mode2  = 0;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        nreset = 1'b0;
        test_reset();
        test_nor_ideal();
        test_stuck0();
        test_and_loops();
        test_saturation();
        test_busy_start_and_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
